// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package prog_loader_pkg;

    // End-of-program marker; never written to instruction memory.
    localparam logic [31:0] TERM_WORD_DEF = 32'h0000_0FFF;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_DONE
    } ld_state_e;

    // Words arrive most significant byte first: shift left, new byte at the bottom.
    function automatic logic [31:0] shift_in_byte(input logic [31:0] word, input logic [7:0] b);
        return {word[23:0], b};
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop input synchronizer plus mid-bit sampling FSM.
// byte_vld_o and frame_err_o are single-cycle pulses.
module uart_rx_byte
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 86
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rx_sync;
    rx_state_e        state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
        end
    end

    // Receive FSM: find the start bit centre, then sample each bit one bit-time apart.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= RX_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            byte_o      <= '0;
            byte_vld_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            byte_vld_o  <= 1'b0;
            frame_err_o <= 1'b0;
            case (state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_sync) state <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        // A line that is high again at the start-bit centre was a glitch.
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt        <= '0;
                        shreg[bit_idx] <= rx_sync;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_sync) begin
                            byte_o     <= shreg;
                            byte_vld_o <= 1'b1;
                            state      <= RX_IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= RX_WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Program loader: assembles UART bytes into 32-bit words (MSB first) and
// writes them to sequential imem addresses until the terminator word.
module uart_prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 86,
    parameter int          ADDR_W       = 14,
    parameter int          MAX_WORDS    = 16384,
    parameter logic [31:0] TERM_WORD    = TERM_WORD_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    input  logic              en_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              frame_err_o,
    output logic              ovf_err_o,
    output logic [ADDR_W:0]   word_cnt_o
);

    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(MAX_WORDS);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    logic [7:0]      rx_byte;
    logic            rx_vld;
    logic            rx_ferr;
    ld_state_e       state;
    logic [1:0]      byte_idx;
    logic [31:0]     asm_word;
    logic [31:0]     next_word;
    logic [ADDR_W:0] cnt_next;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rx_i       (rx_i),
        .byte_o     (rx_byte),
        .byte_vld_o (rx_vld),
        .frame_err_o(rx_ferr)
    );

    assign next_word = shift_in_byte(asm_word, rx_byte);
    assign cnt_next  = word_cnt_o + CNT_ONE;
    assign busy_o    = (state == LD_LOAD);

    // Loader FSM: word assembly, write strobe, count and sticky status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= LD_IDLE;
            byte_idx    <= '0;
            asm_word    <= '0;
            we_o        <= 1'b0;
            addr_o      <= '0;
            wdata_o     <= '0;
            done_o      <= 1'b0;
            frame_err_o <= 1'b0;
            ovf_err_o   <= 1'b0;
            word_cnt_o  <= '0;
        end else begin
            we_o <= 1'b0;
            if (!en_i) begin
                // Abort: session cleared; addr/wdata keep their last values.
                state       <= LD_IDLE;
                byte_idx    <= '0;
                done_o      <= 1'b0;
                frame_err_o <= 1'b0;
                ovf_err_o   <= 1'b0;
                word_cnt_o  <= '0;
            end else begin
                case (state)
                    LD_IDLE: begin
                        state       <= LD_LOAD;
                        byte_idx    <= '0;
                        done_o      <= 1'b0;
                        frame_err_o <= 1'b0;
                        ovf_err_o   <= 1'b0;
                        word_cnt_o  <= '0;
                    end
                    LD_LOAD: begin
                        // Count advances the cycle after the write strobe.
                        if (we_o) begin
                            word_cnt_o <= cnt_next;
                            if (cnt_next == CNT_MAX) begin
                                ovf_err_o <= 1'b1;
                                state     <= LD_DONE;
                            end
                        end
                        if (rx_ferr) begin
                            frame_err_o <= 1'b1;
                            byte_idx    <= '0;
                        end else if (rx_vld) begin
                            asm_word <= next_word;
                            if (byte_idx == 2'd3) begin
                                byte_idx <= '0;
                                if (next_word == TERM_WORD) begin
                                    done_o <= 1'b1;
                                    state  <= LD_DONE;
                                end else begin
                                    we_o    <= 1'b1;
                                    addr_o  <= word_cnt_o[ADDR_W-1:0];
                                    wdata_o <= next_word;
                                end
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                            end
                        end
                    end
                    LD_DONE: ;
                    default: state <= LD_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with a word-level reference model.
module tb_uart_prog_loader;

    localparam int          CPB  = 16;
    localparam int          AW   = 14;
    localparam int          MAXW = 16;
    localparam logic [31:0] TERM = 32'h0000_0FFF;

    logic          clk;
    logic          rst_n;
    logic          rx;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          busy;
    logic          done;
    logic          ferr;
    logic          ovf;
    logic [AW:0]   cnt;

    int errors = 0;
    int checks = 0;

    // expected writes: {addr, data}
    logic [AW+31:0] exp_q[$];

    // reference model state
    logic [31:0] m_word;
    int          m_idx;
    int          m_cnt;
    bit          m_load;
    bit          m_done;
    bit          m_ovf;
    bit          m_ferr;
    int          good_bytes = 0;
    int          seen_bytes = 0;
    logic [AW-1:0] last_addr = '0;
    logic [31:0]   last_data = '0;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .MAX_WORDS   (MAXW),
        .TERM_WORD   (TERM)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rx_i       (rx),
        .en_i       (en),
        .we_o       (we),
        .addr_o     (addr),
        .wdata_o    (wdata),
        .busy_o     (busy),
        .done_o     (done),
        .frame_err_o(ferr),
        .ovf_err_o  (ovf),
        .word_cnt_o (cnt)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model
    function automatic void model_clear();
        m_word = '0;
        m_idx  = 0;
        m_cnt  = 0;
        m_done = 0;
        m_ovf  = 0;
        m_ferr = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        good_bytes++;
        if (en && m_load) begin
            m_word = {m_word[23:0], b};
            m_idx++;
            if (m_idx == 4) begin
                m_idx = 0;
                if (m_word == TERM) begin
                    m_done = 1;
                    m_load = 0;
                end else begin
                    exp_q.push_back({AW'(m_cnt), m_word});
                    m_cnt++;
                    if (m_cnt == MAXW) begin
                        m_ovf  = 1;
                        m_load = 0;
                    end
                end
            end
        end
    endfunction

    function automatic void model_ferr();
        if (en && m_load) begin
            m_ferr = 1;
            m_idx  = 0;
        end
    endfunction

    // compare process: every write and every received byte
    always @(negedge clk) begin
        if (rst_n) begin
            if (dut.u_rx.byte_vld_o) seen_bytes++;
            if (we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %08h, none expected", addr, wdata);
                end else begin
                    logic [AW+31:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(addr), 64'(e[AW+31:32]));
                    check("wr_data", 64'(wdata), 64'(e[31:0]));
                end
                last_addr = addr;
                last_data = wdata;
            end
        end
    end

    // drivers
    task automatic send_byte(input logic [7:0] b, input int stretch = 0, input bit stop_ok = 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB + stretch) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (stop_ok) model_byte(b);
        else         model_ferr();
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int stretch = 0);
        send_byte(w[31:24], stretch);
        send_byte(w[23:16], stretch);
        send_byte(w[15:8], stretch);
        send_byte(w[7:0], stretch);
    endtask

    task automatic set_en(input bit v);
        @(negedge clk);
        en = v;
        model_clear();
        m_load = v;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".we"},    64'(we),    64'd0);
        check({name, ".addr"},  64'(addr),  64'd0);
        check({name, ".wdata"}, 64'(wdata), 64'd0);
        check({name, ".busy"},  64'(busy),  64'd0);
        check({name, ".done"},  64'(done),  64'd0);
        check({name, ".ferr"},  64'(ferr),  64'd0);
        check({name, ".ovf"},   64'(ovf),   64'd0);
        check({name, ".cnt"},   64'(cnt),   64'd0);
    endtask

    task automatic checkpoint(input string name);
        repeat (4) @(negedge clk);
        check({name, ".cnt"},   64'(cnt),  64'(m_cnt));
        check({name, ".done"},  64'(done), 64'(m_done));
        check({name, ".ovf"},   64'(ovf),  64'(m_ovf));
        check({name, ".ferr"},  64'(ferr), 64'(m_ferr));
        check({name, ".busy"},  64'(busy), 64'(en && m_load));
        check({name, ".pend"},  64'(exp_q.size()), 64'd0);
        check({name, ".bytes"}, 64'(seen_bytes), 64'(good_bytes));
    endtask

    // main sequence
    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        rx    = 1'b1;
        model_clear();
        m_load = 0;
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // single word
        set_en(1'b1);
        send_word(32'hDEAD_BEEF);
        checkpoint("single");
        check("single.lit_data", 64'(last_data), 64'hDEAD_BEEF);
        check("single.lit_addr", 64'(last_addr), 64'd0);
        check("single.lit_cnt",  64'(cnt),       64'd1);

        // start bit stretched to the tolerance limit
        send_word(32'h0123_4567, CPB / 2 - 1);
        send_word(32'h89AB_CDEF, CPB / 2 - 1);
        checkpoint("stretch");
        check("stretch.lit_data", 64'(last_data), 64'h89AB_CDEF);

        // short low glitch on the line
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB / 2 - 3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checkpoint("glitch");
        send_word(32'h0BAD_F00D);
        checkpoint("after_glitch");

        // fresh session, frame error drops the partial word
        set_en(1'b0);
        checkpoint("abort1");
        set_en(1'b1);
        send_byte(8'hAA);
        send_byte(8'h55, 0, 1'b0);
        send_word(32'h1122_3344);
        checkpoint("frame");
        check("frame.lit_ferr", 64'(ferr),      64'd1);
        check("frame.lit_data", 64'(last_data), 64'h1122_3344);
        check("frame.lit_addr", 64'(last_addr), 64'd0);

        // reset in the middle of the third byte
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk);
        rx = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        m_load = en;
        repeat (3) @(negedge clk);
        check_all_zero("midreset");
        rx    = 1'b1;
        rst_n = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_word(32'hCAFE_F00D);
        checkpoint("post_reset");
        check("post_reset.lit_addr", 64'(last_addr), 64'd0);

        // full program terminated by the marker, then traffic while done
        set_en(1'b0);
        set_en(1'b1);
        for (int i = 0; i < 12; i++)
            send_word((32'h0101_0101 * (i + 1)) ^ 32'hA500_0000);
        send_word(TERM);
        checkpoint("program");
        check("program.lit_cnt",  64'(cnt),  64'd12);
        check("program.lit_done", 64'(done), 64'd1);
        send_word(32'h7777_7777);
        checkpoint("after_done");

        // overflow: one word more than capacity
        set_en(1'b0);
        set_en(1'b1);
        for (int i = 0; i <= MAXW; i++)
            send_word(32'h5000_0000 + 32'(i));
        checkpoint("overflow");
        check("overflow.lit_cnt",  64'(cnt),  64'd16);
        check("overflow.lit_ovf",  64'(ovf),  64'd1);
        check("overflow.lit_done", 64'(done), 64'd0);

        // abort clears the session; next word lands at address 0
        set_en(1'b0);
        checkpoint("abort2");
        check("abort2.lit_cnt", 64'(cnt), 64'd0);
        set_en(1'b1);
        send_word(32'h1357_9BDF);
        checkpoint("restart");
        check("restart.lit_addr", 64'(last_addr), 64'd0);
        check("restart.lit_data", 64'(last_data), 64'h1357_9BDF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Receives the serial program-load stream on the FPGA/SoC side and writes each 32-bit word into instruction memory.
- The stream is 8N1 UART, bytes LSB-first, 4 bytes per word, most significant byte first.
- The stream ends with terminator word 0x00000FFF.
- Sits between the board RX pin and the imem write port; holds the core off until `done_o`.

Parameters:
- CLKS_PER_BIT, 86, clock cycles per UART bit (8600 ns bit at 100 ns clock).
- ADDR_W, 14, imem word-address width (16384 words).
- MAX_WORDS, 16384, maximum number of words accepted before overflow.
- TERM_WORD, 32'h00000FFF, end-of-program marker; this word is never written.

Ports:
- `clk_i`, in, 1, system clock.
- `rst_ni`, in, 1, asynchronous active-low reset.
- `rx_i`, in, 1, asynchronous serial input; idles high.
- `en_i`, in, 1, load enable; low aborts the session and clears it.
- `we_o`, out, 1, imem write strobe, one cycle per word.
- `addr_o`, out, ADDR_W, imem word address.
- `wdata_o`, out, 32, imem write data.
- `busy_o`, out, 1, session active: `en_i` high and not done.
- `done_o`, out, 1, terminator received (sticky).
- `frame_err_o`, out, 1, stop bit was 0 (sticky).
- `ovf_err_o`, out, 1, MAX_WORDS reached without terminator (sticky).
- `word_cnt_o`, out, ADDR_W+1, number of words written.

Behaviour:
- **Reset** (`rst_ni` low, asynchronous): all outputs 0. Synchronizer flops reset to 1. Both FSMs go to IDLE.
- **Input synchronizer:** `rx_i` passes through a 2-flop synchronizer; all decisions use the synchronized value.
- **RX FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: go to START on synchronized rx = 0.
  - START: wait CLKS_PER_BIT/2 cycles (integer divide), then resample. If 0, go to DATA with bit counter = 0. If 1, treat as a glitch and return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles at mid-bit; bit i goes to byte[i]. After bit 7, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If 1: pulse `byte_vld` for one cycle and return to IDLE.
    - If 0: set `frame_err_o`, drop the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: return to IDLE once rx = 1.
- **Start-bit tolerance:** a start bit stretched by up to CLKS_PER_BIT/2-1 extra cycles must still decode correctly.
- **Loader FSM states:** IDLE, LOAD, DONE.
  - IDLE: go to LOAD when `en_i` = 1. On entry to LOAD, clear byte index, word count and the sticky flags.
  - LOAD: on each `byte_vld`, shift the byte into the assembly register; the first byte lands in [31:24]. Byte index runs 0..3.
  - LOAD, on the 4th byte, with the assembled word:
    - Word == TERM_WORD: set `done_o` and go to DONE; no write.
    - Otherwise: the next cycle drives `we_o` = 1, `addr_o` = `word_cnt_o`[ADDR_W-1:0] and `wdata_o` = word. The cycle after that, `word_cnt_o` increments.
    - If the incremented count equals MAX_WORDS: set `ovf_err_o` and go to DONE.
  - DONE: ignore all bytes. `done_o` and `ovf_err_o` hold.
- **Latency:** `we_o` is asserted exactly 1 cycle after the 4th `byte_vld`; `byte_vld` is asserted 1 cycle after the stop-bit sample.
- **Frame error in LOAD:** the partial word is discarded and byte index resets to 0. Loading continues with the next byte.
- **`en_i` low (any state):** loader goes to IDLE within 1 cycle and `we_o` is forced to 0. `done_o`, `frame_err_o`, `ovf_err_o` and `word_cnt_o` clear. Bytes received while `en_i` is low are discarded.
- **RX FSM independence:** the RX FSM keeps running regardless of `en_i`.
- **`busy_o`:** equals (state == LOAD).
- **Mid-operation reset:** asserting `rst_ni` low during a byte or word abandons it; there is no partial write.
- **Output stability:** `addr_o` and `wdata_o` hold their last values when `we_o` = 0.

Decomposition:
- **Package `prog_loader_pkg`:** TERM_WORD default constant, rx_state_e (IDLE/START/DATA/STOP/WAIT_HIGH), ld_state_e (IDLE/LOAD/DONE).
- **Sub-module `uart_rx_byte`:** synchronizer plus RX FSM. Ports: `clk_i`, `rst_ni`, `rx_i`, `byte_o`[7:0], `byte_vld_o`, `frame_err_o`; parameter CLKS_PER_BIT.
- **Top level:** the top instantiates `uart_rx_byte` and implements the loader FSM.

Test Plan:
- **Single word:** `en_i` = 1; send bytes DE AD BE EF → one `we_o` pulse with `addr_o` = 0, `wdata_o` = 0xDEADBEEF; `word_cnt_o` = 1; `done_o` = 0.
- **Full program:** 255 words followed by 00 00 0F FF → 255 writes at addresses 0..254 with data matching the source file; `done_o` = 1; `word_cnt_o` = 255; no write of 0x00000FFF.
- **Stretched start bit:** each start bit stretched by +10 cycles (1000 ns) → all bytes decoded correctly; `frame_err_o` = 0.
- **Frame error:** send AA, then a byte with stop bit = 0, then 11 22 33 44 → `frame_err_o` = 1, partial word dropped; next write has `wdata_o` = 0x11223344 at `addr_o` = 0.
- **Glitch and reset:**
  - rx low for 20 cycles only → no `byte_vld`, no error.
  - `rst_ni` pulsed low during the 3rd byte of a word → all outputs 0 and no write. After release, the next 4 bytes form word 0.
- **Overflow and `en_i` abort:**
  - With MAX_WORDS = 4, send 5 non-terminator words → 4 writes; `ovf_err_o` = 1; `done_o` = 0.
  - Then drop `en_i` → flags and count clear. Raise `en_i` and send 1 word → write lands at `addr_o` = 0.
